// File: rtl/div_scheduler_if.sv
// Bundle of requester, response and shared-divider signals around div_scheduler.
// "master" is the environment side (requesters plus divider); "slave" is the scheduler.
interface div_scheduler_if #(
   parameter int N_REQ = 3,
   parameter int WIDTH = 32
);
   localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0]       req_valid;
   logic [N_REQ*WIDTH-1:0] req_dividend;
   logic [N_REQ*WIDTH-1:0] req_divisor;
   logic [N_REQ-1:0]       req_ack;

   logic                   resp_valid;
   logic [ID_W-1:0]        resp_id;
   logic [WIDTH-1:0]       resp_quotient;
   logic [WIDTH-1:0]       resp_remainder;
   logic                   resp_err;
   logic                   busy;

   logic                   div_reset;
   logic                   div_start;
   logic [WIDTH-1:0]       div_dividend;
   logic [WIDTH-1:0]       div_divisor;
   logic                   div_done;
   logic [WIDTH-1:0]       div_quotient;
   logic [WIDTH-1:0]       div_remainder;

   modport master (
      output req_valid, req_dividend, req_divisor,
      output div_done, div_quotient, div_remainder,
      input  req_ack, resp_valid, resp_id, resp_quotient, resp_remainder, resp_err, busy,
      input  div_reset, div_start, div_dividend, div_divisor
   );

   modport slave (
      input  req_valid, req_dividend, req_divisor,
      input  div_done, div_quotient, div_remainder,
      output req_ack, resp_valid, resp_id, resp_quotient, resp_remainder, resp_err, busy,
      output div_reset, div_start, div_dividend, div_divisor
   );
endinterface

// File: rtl/div_scheduler.sv
// Round-robin arbiter sharing one iterative divider among N_REQ gain computations,
// with divide-by-zero bypass and a RUN-phase watchdog.
//
// state  | meaning
// IDLE   | waiting for a request; grant and operand latch happen here
// CLR    | one-cycle clear pulse to the divider
// RUN    | divider started, watchdog counting
// RESP   | one-cycle response strobe, divider held in clear
module div_scheduler #(
   parameter int N_REQ   = 3,
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 40
) (
   input logic          clk,
   input logic          reset,
   div_scheduler_if.slave bus
);
   localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CLR  = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;
   localparam logic [1:0] S_RESP = 2'd3;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   logic [1:0]       state;
   logic [7:0]       run_cnt;
   logic [ID_W-1:0]  last_grant;
   logic [ID_W-1:0]  cur_id;
   logic [WIDTH-1:0] opd_dividend;
   logic [WIDTH-1:0] opd_divisor;
   logic [ID_W-1:0]  resp_id_q;
   logic [WIDTH-1:0] resp_q;
   logic [WIDTH-1:0] resp_r;
   logic             resp_err_q;

   logic [WIDTH-1:0] dvd_arr [N_REQ];
   logic [WIDTH-1:0] dvs_arr [N_REQ];
   logic             grant_found;
   logic [ID_W-1:0]  grant_idx;
   logic [ID_W-1:0]  cand_idx;
   int               cand;
   logic [WIDTH-1:0] win_dividend;
   logic [WIDTH-1:0] win_divisor;
   logic [N_REQ-1:0] ack_vec;

   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         dvd_arr[i] = bus.req_dividend[i*WIDTH +: WIDTH];
         dvs_arr[i] = bus.req_divisor[i*WIDTH +: WIDTH];
      end
   end

   // Search starts one past the previous winner so every requester gets a turn.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      cand_idx    = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = int'(last_grant) + k;
         if (cand >= N_REQ) begin
            cand = cand - N_REQ;
         end
         cand_idx = cand[ID_W-1:0];
         if (!grant_found && bus.req_valid[cand_idx]) begin
            grant_found = 1'b1;
            grant_idx   = cand_idx;
         end
      end
   end

   assign win_dividend = dvd_arr[grant_idx];
   assign win_divisor  = dvs_arr[grant_idx];

   always_comb begin
      ack_vec = '0;
      if (state == S_IDLE && grant_found) begin
         ack_vec[grant_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= S_IDLE;
         run_cnt      <= '0;
         last_grant   <= ID_W'(N_REQ - 1);
         cur_id       <= '0;
         opd_dividend <= '0;
         opd_divisor  <= '0;
         resp_id_q    <= '0;
         resp_q       <= '0;
         resp_r       <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               run_cnt <= '0;
               if (grant_found) begin
                  last_grant   <= grant_idx;
                  cur_id       <= grant_idx;
                  opd_dividend <= win_dividend;
                  opd_divisor  <= win_divisor;
                  // A zero divisor never reaches the divider; the answer is known now.
                  if (win_divisor == '0) begin
                     resp_id_q  <= grant_idx;
                     resp_q     <= '1;
                     resp_r     <= win_dividend;
                     resp_err_q <= 1'b1;
                     state      <= S_RESP;
                  end else begin
                     state <= S_CLR;
                  end
               end
            end
            S_CLR: begin
               run_cnt <= '0;
               state   <= S_RUN;
            end
            S_RUN: begin
               if (bus.div_done) begin
                  resp_id_q  <= cur_id;
                  resp_q     <= bus.div_quotient;
                  resp_r     <= bus.div_remainder;
                  resp_err_q <= 1'b0;
                  run_cnt    <= '0;
                  state      <= S_RESP;
               end else if (run_cnt == CNT_LAST) begin
                  resp_id_q  <= cur_id;
                  resp_q     <= '0;
                  resp_r     <= '0;
                  resp_err_q <= 1'b1;
                  run_cnt    <= '0;
                  state      <= S_RESP;
               end else begin
                  run_cnt <= run_cnt + 8'd1;
               end
            end
            S_RESP: begin
               run_cnt <= '0;
               state   <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ack        = ack_vec;
   assign bus.resp_valid     = (state == S_RESP);
   assign bus.resp_id        = resp_id_q;
   assign bus.resp_quotient  = resp_q;
   assign bus.resp_remainder = resp_r;
   assign bus.resp_err       = resp_err_q;
   assign bus.busy           = (state != S_IDLE);
   assign bus.div_reset      = (state != S_RUN);
   assign bus.div_start      = (state == S_RUN);
   assign bus.div_dividend   = opd_dividend;
   assign bus.div_divisor    = opd_divisor;

endmodule

// File: tb/tb_div_scheduler.sv
// Scoreboard bench for div_scheduler: stimulus pushes predicted grants/responses,
// a negedge monitor pops and compares; a behavioural divider answers after div_lat cycles.
module tb_div_scheduler;
   localparam int N  = 3;
   localparam int W  = 32;
   localparam int TO = 40;

   typedef struct {
      int         id;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic       err;
      int         lat;
      logic       zero;
   } exp_t;

   logic clk;
   logic reset;

   div_scheduler_if #(.N_REQ(N), .WIDTH(W)) bus ();

   div_scheduler #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int div_lat  = 5;   // 0 means the divider never finishes
   int m_last   = N - 1;

   exp_t exp_resp[$];
   int   exp_ack[$];

   int           b_cnt [N];
   logic [W-1:0] b_a   [N];
   logic [W-1:0] b_b   [N];

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic exp_t model_resp(int id, logic [W-1:0] a, logic [W-1:0] b);
      exp_t x;
      x.id = id;
      x.zero = (b == 0);
      if (b == 0) begin
         x.q = '1; x.r = a; x.err = 1'b1; x.lat = 1;
      end else if (div_lat != 0 && div_lat <= TO) begin
         x.q = a / b; x.r = a % b; x.err = 1'b0; x.lat = div_lat + 2;
      end else begin
         x.q = '0; x.r = '0; x.err = 1'b1; x.lat = TO + 2;
      end
      return x;
   endfunction

   task automatic check_reset_vals(input string tag);
      check({tag, "_ack"},       bus.req_ack, 0);
      check({tag, "_resp_valid"}, bus.resp_valid, 0);
      check({tag, "_resp_err"},  bus.resp_err, 0);
      check({tag, "_resp_id"},   bus.resp_id, 0);
      check({tag, "_resp_q"},    bus.resp_quotient, 0);
      check({tag, "_resp_r"},    bus.resp_remainder, 0);
      check({tag, "_busy"},      bus.busy, 0);
      check({tag, "_div_start"}, bus.div_start, 0);
      check({tag, "_div_reset"}, bus.div_reset, 1);
      check({tag, "_div_opnds"}, {bus.div_dividend, bus.div_divisor}, 0);
   endtask

   // Behavioural divider: done is shown during the div_lat-th start cycle.
   initial begin : divider_model
      int n;
      n = 0;
      bus.div_done      = 1'b0;
      bus.div_quotient  = '0;
      bus.div_remainder = '0;
      forever begin
         @(posedge clk);
         #1;
         bus.div_quotient  = $urandom;
         bus.div_remainder = $urandom;
         if (bus.div_reset) begin
            n = 0;
            bus.div_done = 1'b0;
         end else if (bus.div_start) begin
            bus.div_done = (div_lat != 0 && n == div_lat - 1);
            if (bus.div_done) begin
               bus.div_quotient  = (bus.div_divisor == 0) ? '1 : bus.div_dividend / bus.div_divisor;
               bus.div_remainder = (bus.div_divisor == 0) ? bus.div_dividend : bus.div_dividend % bus.div_divisor;
            end
            n++;
         end else begin
            bus.div_done = 1'b0;
         end
      end
   end

   initial begin : monitor
      int   cyc, ack_cyc, e;
      bit   inflight, start_seen, have_ref, clr_chk;
      exp_t x, ref_v;
      cyc = 0; ack_cyc = 0; inflight = 0; start_seen = 0; have_ref = 0; clr_chk = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!reset) begin
            inflight = 0;
            clr_chk  = 0;
            have_ref = 1;
            ref_v.id = 0; ref_v.q = '0; ref_v.r = '0; ref_v.err = 1'b0;
         end else begin
            if (clr_chk) begin
               check("clr_cycle", {bus.div_reset, bus.div_start, bus.busy}, 3'b101);
               clr_chk = 0;
            end
            if (inflight && bus.div_start) start_seen = 1;
            if (bus.req_ack != 0) begin
               if (exp_ack.size() == 0) begin
                  n_checks++; n_fail++;
                  $display("FAIL unexpected_ack: got 0x%0h expected none at %0t", bus.req_ack, $time);
               end else begin
                  e = exp_ack.pop_front();
                  check("ack_id", bus.req_ack, 64'(1) << e);
                  check("ack_when_idle", {inflight, bus.busy}, 0);
               end
               if (exp_resp.size() > 0 && !exp_resp[0].zero) clr_chk = 1;
               inflight = 1; ack_cyc = cyc; start_seen = 0;
            end
            if (bus.resp_valid) begin
               if (exp_resp.size() == 0) begin
                  n_checks++; n_fail++;
                  $display("FAIL unexpected_resp: got id %0d expected none at %0t", bus.resp_id, $time);
               end else begin
                  x = exp_resp.pop_front();
                  check("resp_id",  bus.resp_id, x.id);
                  check("resp_q",   bus.resp_quotient, x.q);
                  check("resp_r",   bus.resp_remainder, x.r);
                  check("resp_err", bus.resp_err, x.err);
                  check("latency",  cyc - ack_cyc, x.lat);
                  if (x.zero) check("div0_no_start", start_seen, 0);
                  ref_v = x; have_ref = 1;
               end
               inflight = 0;
            end else if (have_ref) begin
               check("hold_q", bus.resp_quotient, ref_v.q);
               check("hold_r_err_id", {bus.resp_remainder, bus.resp_err, bus.resp_id},
                     {ref_v.r, ref_v.err, 2'(ref_v.id)});
            end
         end
      end
   end

   task automatic run_batch();
      int left[N];
      int served[N];
      int total, budget;
      bit done;
      total = 0;
      for (int i = 0; i < N; i++) begin
         left[i] = b_cnt[i]; served[i] = 0; total += b_cnt[i];
      end
      if (total == 0) return;
      // Reference: visit pending requesters in circular order after the last winner.
      for (int g = 0; g < total; g++) begin
         int c;
         c = -1;
         for (int k = 1; k <= N; k++) begin
            int t;
            t = (m_last + k) % N;
            if (c < 0 && left[t] > 0) c = t;
         end
         exp_ack.push_back(c);
         exp_resp.push_back(model_resp(c, b_a[c], b_b[c]));
         left[c]--;
         m_last = c;
      end
      for (int i = 0; i < N; i++) begin
         bus.req_dividend[i*W +: W] = b_a[i];
         bus.req_divisor[i*W +: W]  = b_b[i];
         bus.req_valid[i] = (b_cnt[i] > 0);
      end
      budget = total * (TO + 6) + 20;
      done = 0;
      while (!done && budget > 0) begin
         @(negedge clk);
         for (int i = 0; i < N; i++) if (bus.req_ack[i]) served[i]++;
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) if (served[i] >= b_cnt[i]) bus.req_valid[i] = 1'b0;
         budget--;
         done = (exp_ack.size() == 0 && exp_resp.size() == 0);
      end
      if (!done) begin
         n_checks++; n_fail++;
         $display("FAIL batch_timeout: got %0d outstanding expected 0", exp_ack.size() + exp_resp.size());
         exp_ack.delete(); exp_resp.delete();
         bus.req_valid = '0;
      end
   endtask

   task automatic single(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input int lat);
      for (int i = 0; i < N; i++) begin
         b_cnt[i] = 0; b_a[i] = '0; b_b[i] = '0;
      end
      b_cnt[id] = 1; b_a[id] = a; b_b[id] = b;
      div_lat = lat;
      run_batch();
   endtask

   initial begin : stimulus
      bit got;
      reset = 1'b1;
      bus.req_valid    = '0;
      bus.req_dividend = '0;
      bus.req_divisor  = '0;
      #5 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1 check_reset_vals("por");
      @(negedge clk) reset = 1'b1;
      @(posedge clk);
      #1;

      // Contention: all held, requester 0 wants two turns -> 0,1,2,0
      for (int i = 0; i < N; i++) begin
         b_cnt[i] = (i == 0) ? 2 : 1;
         b_a[i] = 32'(1000 * (i + 1) + 7);
         b_b[i] = 32'(i + 3);
      end
      div_lat = 4;
      run_batch();

      single(0, 32'd4500, 32'd100, 6);
      single(1, 32'd12, 32'd0, 5);
      single(2, 32'd99, 32'd7, 0);
      single(0, 32'd1000, 32'd33, TO);

      // Reset in RUN cycle 5 with a divider that never finishes
      div_lat = 0;
      exp_ack.push_back(1);
      m_last = 1;
      bus.req_dividend[1*W +: W] = 32'd5000;
      bus.req_divisor[1*W +: W]  = 32'd3;
      bus.req_valid = 3'b010;
      got = 0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         if (bus.req_ack[1]) got = 1;
      end
      check("rst_test_ack_seen", got, 1);
      @(posedge clk);
      #1 bus.req_valid = '0;
      repeat (6) @(posedge clk);
      #1 reset = 1'b0;
      #2 check_reset_vals("midrun");
      m_last = N - 1;
      exp_ack.delete();
      @(negedge clk);
      @(negedge clk) reset = 1'b1;
      repeat (TO + 5) @(posedge clk);
      #1;

      single(2, 32'd777, 32'd10, 3);

      for (int r = 0; r < 25; r++) begin
         int sel, tot;
         tot = 0;
         for (int i = 0; i < N; i++) begin
            b_cnt[i] = $urandom_range(0, 2);
            tot += b_cnt[i];
            b_a[i] = $urandom;
            b_b[i] = ($urandom_range(0, 3) == 0) ? '0 : ($urandom >> $urandom_range(0, 28));
         end
         if (tot == 0) b_cnt[$urandom_range(0, N - 1)] = 1;
         sel = $urandom_range(0, 9);
         if (sel < 7)       div_lat = $urandom_range(1, 12);
         else if (sel == 7) div_lat = 0;
         else               div_lat = $urandom_range(TO - 1, TO + 2);
         run_batch();
      end

      repeat (5) @(posedge clk);
      check("queues_drained", exp_ack.size() + exp_resp.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
